serial_subtractor: RTL and testbench
====================================

# serial_subtractor

- Bit-serial, LSB-first two's-complement subtractor: computes diff = a − b and borrow for WIDTH-bit operands, one bit per clock.
- Built on a single full-subtractor cell and a registered borrow; it is the subtract-side counterpart of the arithmetic cells already in the design.
- Sits in the datapath wherever area matters more than latency, with valid/ready handshakes on both the operand side and the result side.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; WIDTH ≥ 2.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  diff/borrow/overflow hold a completed result.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a − b modulo 2^WIDTH.
- borrow  output  1  1 when unsigned a < b.
- overflow  output  1  signed overflow flag (see Configuration).

## Operation
States: IDLE, RUN, DONE.

- **IDLE**
  - in_ready = 1.
  - On in_valid, capture a and b into shift registers, clear the borrow register and bit counter, then go to RUN.
- **RUN**
  - Each cycle, take LSBs a0 and b0 with borrow-in bin.
    - Difference bit: d = a0 ^ b0 ^ bin.
    - Borrow-out: bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
  - Shift d into diff from the MSB end.
  - Shift a and b right by one.
  - Register bout as the next bin.
  - Increment the counter.
  - After the WIDTH-th bit: latch the final bout into borrow and go to DONE.
- **DONE**
  - out_valid = 1.
  - diff, borrow and overflow are stable.
  - On out_ready, go to IDLE.
- **Result hold:** diff, borrow and overflow keep their value after leaving DONE until the next result completes.
- **Operands ignored:** in_valid in RUN or DONE has no effect; operands are not sampled.
- **No overlap:** the block never accepts in the DONE→IDLE transition cycle; in_ready rises the cycle after out_ready is taken.
- **Counter:** $clog2(WIDTH)+1 bits wide, with no wrap within an operation.
- **Reset (async, any state, including mid-RUN):**
  - State → IDLE.
  - diff = 0, borrow = 0, overflow = 0.
  - out_valid = 0, in_ready = 1.
  - Shift registers and counter are cleared.
  - The partial result is discarded.

## Timing
- **Acceptance:** operands are accepted on the edge E0 where in_valid && in_ready.
- **Per-bit:** bit i is computed on edge E(i+1).
- **Completion:** on edge E(WIDTH), state becomes DONE and out_valid is seen high immediately after it. Latency from acceptance to out_valid is WIDTH cycles.
- **Throughput:** one operation per WIDTH+2 cycles with out_ready held high.
- **Output decode:** in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.

## Configuration
- **Macro:** SERIAL_SUBTRACTOR_SIGNED_EN.
- **Defined:**
  - overflow is registered at the transition to DONE.
  - Formula: overflow = (a_msb != b_msb) && (diff_msb != a_msb), where a_msb and b_msb are the captured operand MSBs.
  - The block keeps one extra flop that holds the original sign of a and one for b.
- **Not defined:**
  - overflow is tied to 0.
  - The sign flops are absent.
  - All other behaviour is identical.

## Structure
- **Package serial_subtractor_pkg:**
  - State enum (IDLE, RUN, DONE).
  - Default WIDTH constant.
- **Sub-module full_subtractor:**
  - Combinational.
  - Inputs a, b, bin; outputs d, bout.
  - Instantiated once in the RUN datapath.

## Test plan (WIDTH = 8)
- 0x05 − 0x03 → diff 0x02, borrow 0, out_valid exactly 8 cycles after acceptance.
- 0x03 − 0x05 → diff 0xFE, borrow 1.
- 0x80 − 0x01 → diff 0x7F, borrow 0, overflow 1 with macro defined, 0 without.
- Hold out_ready low 5 cycles in DONE; pulse in_valid with new operands meanwhile → out_valid and diff stable, in_ready 0, new operands ignored; after out_ready, in_ready 1 the next cycle.
- Assert rst_n low after 3 bits of 0xFF − 0x01 → all outputs at reset values; then 0x10 − 0x10 → diff 0x00, borrow 0.
- Back-to-back 0x00 − 0x00 then 0x00 − 0xFF with out_ready and in_valid high → results 0x00/borrow 0, then 0x01/borrow 1, spaced WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and default width for serial_subtractor
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational one-bit full subtractor cell (a - b - bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow when b exceeds a outright, or when a equals b and a borrow ripples in.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor; SERIAL_SUBTRACTOR_SIGNED_EN adds signed overflow
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the low WIDTH-1 result bits while running; the final bit joins at completion.
  logic [WIDTH-2:0] diff_sr;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             d_bit;
  logic             bout;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin),
    .d    (d_bit),
    .bout (bout)
  );

  // Handshakes come straight from the registered state, never from in_valid/out_ready.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Control FSM plus the serial datapath; diff/borrow only update when a result completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      cnt     <= '0;
      bin     <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            bin   <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          diff_sr <= (WIDTH-1)'({d_bit, diff_sr} >> 1);
          bin     <= bout;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff   <= {d_bit, diff_sr};
            borrow <= bout;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
  logic a_sign;
  logic b_sign;

  // Keep the operand signs (the shift registers lose them) and flag signed overflow at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sign <= a[WIDTH-1];
      b_sign <= b[WIDTH-1];
    end else if (state == RUN && cnt == LAST) begin
      overflow <= (a_sign != b_sign) && (d_bit != a_sign);
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (WIDTH = 8)
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         overflow;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t last_exp;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.d  = x - y;
    e.br = (x < y);
`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
    e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
`else
    e.ov = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic check_front(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      last_exp = exp_q.pop_front();
      chk({tag, "_diff"}, 32'(diff), 32'(last_exp.d));
      chk({tag, "_borrow"}, 32'(borrow), 32'(last_exp.br));
      chk({tag, "_overflow"}, 32'(overflow), 32'(last_exp.ov));
    end
  endtask

  // Called at #1 after an edge with the block idle; returns at #1 after the acceptance edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("send_in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    push_exp(x, y);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check_front(tag);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    time t0;
    time t1;
    int  nacc;
    int  nres;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic positive result and acceptance-to-out_valid latency.
    send(8'h05, 8'h03);
    chk("t1_in_ready_busy", 32'(in_ready), 32'd0);
    wait_result("t1", W);
    chk("t1_diff_const", 32'(diff), 32'h02);
    consume("t1");

    // Negative result wraps and borrows.
    send(8'h03, 8'h05);
    wait_result("t2", W);
    chk("t2_diff_const", 32'(diff), 32'hFE);
    consume("t2");

    // Signed overflow corner.
    send(8'h80, 8'h01);
    wait_result("t3", W);
    consume("t3");

    // Stall in DONE while new operands are offered.
    send(8'h40, 8'h10);
    wait_result("t4", W);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      chk("t4_hold_out_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_diff", 32'(diff), 32'(last_exp.d));
      chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    consume("t4");
    repeat (3) begin
      @(posedge clk); #1;
      chk("t4_ignored_out_valid", 32'(out_valid), 32'd0);
      chk("t4_result_hold", 32'(diff), 32'(last_exp.d));
    end

    // Asynchronous reset mid-RUN discards the partial result.
    send(8'hFF, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_diff", 32'(diff), 32'd0);
    chk("t5_rst_borrow", 32'(borrow), 32'd0);
    chk("t5_rst_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h10, 8'h10);
    wait_result("t5", W);
    consume("t5");

    // Back-to-back operations with out_ready and in_valid held high.
    in_valid = 1'b1; a = 8'h00; b = 8'h00; out_ready = 1'b1;
    nacc = 0; nres = 0; t0 = 0; t1 = 0;
    for (int c = 0; c < 60 && nres < 2; c++) begin
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        push_exp(a, b);
        nacc++;
        if (nacc == 1) begin a = 8'h00; b = 8'hFF; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        check_front("t6");
        if (nres == 0) t0 = $time; else t1 = $time;
        nres++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t6_results", 32'(nres), 32'd2);
    chk("t6_spacing", 32'(t1 - t0), 32'((W + 2) * 10));
    chk("t6_last_diff", 32'(diff), 32'h01);
    chk("t6_last_borrow", 32'(borrow), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
